// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequential ALU.
// Holds the opcode encodings and the controller state encodings so the
// controller and any future users agree on one set of values.
package alu_pkg;

  // Operation encodings carried on the 4-bit opcode port; all others illegal.
  typedef enum logic [3:0] {
    OP_BEQ = 4'd2,
    OP_BLT = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_MUL = 4'd8,
    OP_SLL = 4'd9,
    OP_SRL = 4'd10
  } opcode_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True when the opcode is routed to the multi-cycle multiplier.
  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier -- shift-add multiplier datapath, one multiplier bit per step.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears all state)
//   load            : capture operands and clear the accumulator
//   step            : consume one multiplier bit
//   a, b            : multiplicand / multiplier (sampled on load)
//   product         : accumulator including the partial product of the bit
//                     currently being consumed; after the last step is
//                     applied this is the low WIDTH bits of a*b
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] partial_s;

  // Next-state for the accumulator and the two shifting operand registers.
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    // Bits shifted past the top of the multiplicand only affect the
    // discarded upper half of the product, so truncation is safe.
    partial_s = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
    product   = acc_q + partial_s;
    if (load) begin
      acc_d    = {WIDTH{1'b0}};
      mcand_d  = a;
      mplier_d = b;
    end else if (step) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1'b1;
      mplier_d = mplier_q >> 1'b1;
    end else begin
      acc_d    = acc_q;
    end
  end

  // Datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu -- sequential ALU with a single-cycle execute path and a
// WIDTH-cycle shift-add multiply path.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : request, only accepted in IDLE
//   opcode          : operation select (see alu_pkg::opcode_e)
//   inputA, inputB  : operands; shifts use inputB[$clog2(WIDTH)-1:0]
//   busy            : operation in flight (EXEC or MULT)
//   done            : one-cycle pulse when result/flags are valid
//   result          : arithmetic/logic result
//   updatePC        : branch taken flag (BEQ/BLT only)
//   zero            : result == 0
//   illegal         : unsupported opcode, valid with done
// All outputs come straight from flops.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             updatePC,
  output logic             zero,
  output logic             illegal
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             update_pc_q, update_pc_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             mul_load_s;
  logic             mul_step_s;
  logic [WIDTH-1:0] mul_product_s;
  logic [WIDTH+1:0] exec_s;

  // Single-cycle operations; packs {branch_taken, illegal, result}.
  // MUL never reaches here because the controller routes it to MULT.
  function automatic logic [WIDTH+1:0] exec_op(input logic [3:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             br;
    logic             ill;
    r   = {WIDTH{1'b0}};
    br  = 1'b0;
    ill = 1'b0;
    case (op)
      OP_BEQ:  br = (a == b);
      OP_BLT:  br = SIGNED_CMP ? ($signed(a) < $signed(b)) : (a < b);
      OP_ADD:  r  = a + b;
      OP_SUB:  r  = a - b;
      OP_AND:  r  = a & b;
      OP_OR:   r  = a | b;
      OP_SLL:  r  = a << b[SH_W-1:0];
      OP_SRL:  r  = a >> b[SH_W-1:0];
      default: ill = 1'b1;
    endcase
    return {br, ill, r};
  endfunction

  seq_multiplier #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load_s),
    .step    (mul_step_s),
    .a       (inputA),
    .b       (inputB),
    .product (mul_product_s)
  );

  // Controller next-state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    update_pc_d = update_pc_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    mul_load_s  = 1'b0;
    mul_step_s  = 1'b0;
    exec_s      = exec_op(op_q, a_q, b_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = opcode;
          a_d   = inputA;
          b_d   = inputB;
          cnt_d = {CNT_W{1'b0}};
          if (is_mul(opcode)) begin
            // Multiplier captures the operands directly off the ports.
            mul_load_s = 1'b1;
            state_d    = ST_MULT;
          end else begin
            state_d    = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        update_pc_d = exec_s[WIDTH+1];
        illegal_d   = exec_s[WIDTH];
        result_d    = exec_s[WIDTH-1:0];
        zero_d      = (exec_s[WIDTH-1:0] == {WIDTH{1'b0}});
        state_d     = ST_DONE;
      end
      ST_MULT: begin
        mul_step_s = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Final step: the product port already includes this bit.
          result_d    = mul_product_s;
          zero_d      = (mul_product_s == {WIDTH{1'b0}});
          update_pc_d = 1'b0;
          illegal_d   = 1'b0;
          state_d     = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_MULT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_EXEC) || (state_d == ST_MULT);
  end

  // State, captured operands and output registers; reset wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 4'd0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      update_pc_q <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      update_pc_q <= update_pc_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign updatePC = update_pc_q;
  assign zero     = zero_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- directed bench for seq_alu (WIDTH=32). Two instances share
// all inputs: one with signed BLT and one with unsigned BLT.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] inputA;
  logic [31:0] inputB;

  logic        busy_s, done_s, upc_s, zero_s, illegal_s;
  logic [31:0] result_s;
  logic        busy_u, done_u, upc_u, zero_u, illegal_u;
  logic [31:0] result_u;

  int n_checks = 0;
  int n_err    = 0;
  int lat;
  int busy_cnt;
  int dones;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .inputA(inputA), .inputB(inputB), .busy(busy_s), .done(done_s),
    .result(result_s), .updatePC(upc_s), .zero(zero_s), .illegal(illegal_s)
  );

  seq_alu #(.WIDTH(32), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .inputA(inputA), .inputB(inputB), .busy(busy_u), .done(done_u),
    .result(result_u), .updatePC(upc_u), .zero(zero_u), .illegal(illegal_u)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a falling edge and wait (bounded) for done.
  // With poke set, a second ADD request is thrown at the DUT mid-flight.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output int l, output int bc);
    opcode = op;
    inputA = a;
    inputB = b;
    start  = 1'b1;
    l  = 0;
    bc = 0;
    do begin
      @(negedge clk);
      l++;
      start = 1'b0;
      if (busy_s) bc++;
      if (poke && l == 5) begin
        start  = 1'b1;
        opcode = 4'd4;
        inputA = 32'h0000_FFFF;
        inputB = 32'h0000_0003;
      end
    end while (!done_s && l < 100);
  endtask

  // Checks made at the done cycle for both instances.
  task automatic check_out(input string tag, input logic [31:0] exp_res,
                           input logic exp_upc_s, input logic exp_upc_u,
                           input logic exp_zero, input logic exp_ill);
    check({tag, ".result"},   result_s,  exp_res);
    check({tag, ".result_u"}, result_u,  exp_res);
    check({tag, ".upc"},      upc_s,     exp_upc_s);
    check({tag, ".upc_u"},    upc_u,     exp_upc_u);
    check({tag, ".zero"},     zero_s,    exp_zero);
    check({tag, ".illegal"},  illegal_s, exp_ill);
    check({tag, ".done_u"},   done_u,    1'b1);
  endtask

  // Next cycle is IDLE: done must have dropped and the result must hold.
  task automatic after_done(input string tag, input logic [31:0] exp_res);
    @(negedge clk);
    check({tag, ".done_pulse"}, done_s,   1'b0);
    check({tag, ".hold"},       result_s, exp_res);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 4'd0;
    inputA = 32'd0;
    inputB = 32'd0;
    repeat (3) @(negedge clk);
    check("rst.busy",     busy_s,    1'b0);
    check("rst.done",     done_s,    1'b0);
    check("rst.result",   result_s,  32'd0);
    check("rst.upc",      upc_s,     1'b0);
    check("rst.zero",     zero_s,    1'b0);
    check("rst.illegal",  illegal_s, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_op(4'd4, 32'd4, 32'd2, 1'b0, lat, busy_cnt);
    check("add.lat",  lat,      2);
    check("add.busy", busy_cnt, 1);
    check_out("add", 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("add", 32'd6);

    run_op(4'd5, 32'd5, 32'd9, 1'b0, lat, busy_cnt);
    check_out("sub_neg", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("sub_neg", 32'hFFFF_FFFC);
    run_op(4'd5, 32'd9, 32'd9, 1'b0, lat, busy_cnt);
    check_out("sub_zero", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    after_done("sub_zero", 32'd0);

    run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, busy_cnt);
    check_out("blt_m1_1", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    after_done("blt_m1_1", 32'd0);
    run_op(4'd3, 32'd1, 32'hFFFF_FFFF, 1'b0, lat, busy_cnt);
    check_out("blt_1_m1", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    after_done("blt_1_m1", 32'd0);
    run_op(4'd2, 32'd6, 32'd6, 1'b0, lat, busy_cnt);
    check_out("beq_eq", 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    after_done("beq_eq", 32'd0);
    run_op(4'd2, 32'd6, 32'd7, 1'b0, lat, busy_cnt);
    check_out("beq_ne", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    after_done("beq_ne", 32'd0);

    run_op(4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, lat, busy_cnt);
    check_out("and", 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("and", 32'h00F0_1200);
    run_op(4'd7, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, lat, busy_cnt);
    check_out("or", 32'hFFF0_FF34, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("or", 32'hFFF0_FF34);
    run_op(4'd10, 32'h8000_0000, 32'd31, 1'b0, lat, busy_cnt);
    check_out("srl31", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("srl31", 32'd1);
    run_op(4'd10, 32'h0000_00F0, 32'd36, 1'b0, lat, busy_cnt);
    check_out("srl_wrap", 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("srl_wrap", 32'h0000_000F);
    run_op(4'd9, 32'h0000_ABCD, 32'd0, 1'b0, lat, busy_cnt);
    check_out("sll0", 32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("sll0", 32'h0000_ABCD);

    run_op(4'd8, 32'h0001_0000, 32'h0001_0001, 1'b1, lat, busy_cnt);
    check("mul.lat",  lat,      33);
    check("mul.busy", busy_cnt, 32);
    check_out("mul_trunc", 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("mul_trunc", 32'h0001_0000);
    run_op(4'd8, 32'd7, 32'd6, 1'b0, lat, busy_cnt);
    check("mul7x6.lat", lat, 33);
    check_out("mul7x6", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("mul7x6", 32'd42);
    run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, busy_cnt);
    check_out("mul_max", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("mul_max", 32'd1);

    run_op(4'd15, 32'd3, 32'd4, 1'b0, lat, busy_cnt);
    check("ill15.lat", lat, 2);
    check_out("ill15", 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    after_done("ill15", 32'd0);
    run_op(4'd9, 32'd1, 32'd31, 1'b0, lat, busy_cnt);
    check_out("sll31", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("sll31", 32'h8000_0000);
    run_op(4'd0, 32'd1, 32'd1, 1'b0, lat, busy_cnt);
    check_out("ill0", 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    after_done("ill0", 32'd0);

    // Abort a multiply 10 cycles in; zero/illegal are high beforehand.
    opcode = 4'd8;
    inputA = 32'd3;
    inputB = 32'd5;
    start  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort.busy_before", busy_s, 1'b1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("abort.busy",    busy_s,    1'b0);
    check("abort.done",    done_s,    1'b0);
    check("abort.result",  result_s,  32'd0);
    check("abort.upc",     upc_s,     1'b0);
    check("abort.zero",    zero_s,    1'b0);
    check("abort.illegal", illegal_s, 1'b0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_s || busy_s) dones++;
    end
    check("abort.no_done", dones, 0);

    run_op(4'd4, 32'd1, 32'd1, 1'b0, lat, busy_cnt);
    check("post_abort.lat", lat, 2);
    check_out("post_abort_add", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("post_abort_add", 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
